// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and pmem responder state
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  localparam int PMEM_CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc3b_pmem_state;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - 128-bit line storage with resettable per-line valid bits
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_BITS-1:0] idx,
  input  lc3b_data            wdata,
  output lc3b_data            rdata,
  output logic                valid
);

  localparam int LINES = 1 << IDX_BITS;

  // Line data is deliberately left unreset; the valid bits mask stale contents.
  lc3b_data          lines [LINES];
  logic [LINES-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      lines[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  assign rdata = lines[idx];
  assign valid = valid_q[idx];

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line memory answering the cache pmem interface
module pmem_responder
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 8,
  parameter int LATENCY  = 10
) (
  input  logic     clk,
  input  logic     rst,
  input  lc3b_word pmem_address,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_data pmem_wdata,
  output lc3b_data pmem_rdata,
  output logic     pmem_resp,
  output logic     pmem_error
);

  localparam logic [PMEM_CNT_BITS-1:0] CNT_LOAD = PMEM_CNT_BITS'(LATENCY - 1);

  lc3b_pmem_state             state;
  logic [PMEM_CNT_BITS-1:0]   cnt;
  logic [IDX_BITS-1:0]        idx_q;
  logic                       op_write_q;
  lc3b_data                   wdata_q;

  logic [IDX_BITS-1:0]        addr_idx;
  logic [IDX_BITS-1:0]        arr_idx;
  logic                       arr_we;
  logic                       arr_valid;
  lc3b_data                   arr_rdata;
  lc3b_data                   line_rdata;
  logic                       req_held;
  logic                       unused_addr;

  assign addr_idx    = pmem_address[IDX_BITS+3:4];
  assign unused_addr = &{1'b0, pmem_address};

  // In IDLE the array is addressed straight from the request so a LATENCY=1
  // read can capture its line on the acceptance edge.
  assign arr_idx    = (state == IDLE) ? addr_idx : idx_q;
  assign arr_we     = (state == RESP) && op_write_q && !rst;
  assign line_rdata = arr_valid ? arr_rdata : '0;
  assign req_held   = op_write_q ? pmem_write : pmem_read;

  pmem_line_array #(
    .IDX_BITS(IDX_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .rdata (arr_rdata),
    .valid (arr_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      pmem_error <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            idx_q      <= addr_idx;
            op_write_q <= pmem_write;
            wdata_q    <= pmem_wdata;
            if (pmem_read && pmem_write) begin
              pmem_error <= 1'b1;
            end
            if (LATENCY == 1) begin
              state     <= RESP;
              cnt       <= '0;
              pmem_resp <= 1'b1;
              if (!pmem_write) begin
                pmem_rdata <= line_rdata;
              end
            end else begin
              state <= BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (!req_held) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt <= PMEM_CNT_BITS'(1)) begin
            // Response is registered, so RESP is entered one edge early.
            state     <= RESP;
            cnt       <= '0;
            pmem_resp <= 1'b1;
            if (!op_write_q) begin
              pmem_rdata <= line_rdata;
            end
          end else begin
            cnt <= cnt - PMEM_CNT_BITS'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Physical-memory responder for the line-based `pmem_*` interface driven by the L1 cache controller. It accepts one 128-bit line read or write at a time and holds the requested line in an internal array. After a programmable fixed latency it answers with a one-cycle `pmem_resp`. It serves as the memory end of the cache in system simulation and as the memory stub in the cache bench.

## Interface
- `IDX_BITS`, default 8: line-index width; the array holds 2^IDX_BITS lines of 16 bytes.
- `LATENCY`, default 10: cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `pmem_address`  in  16 (`lc3b_word`)  byte address; bits [3:0] are ignored, the index is bits [IDX_BITS+3:4], and upper bits alias.
- `pmem_read`  in  1  line read request; held by the requester until `pmem_resp`.
- `pmem_write`  in  1  line write request; held by the requester until `pmem_resp`.
- `pmem_wdata`  in  128 (`lc3b_data`)  write line.
- `pmem_rdata`  out  128 (`lc3b_data`)  read line; valid in the `pmem_resp` cycle and held until the next read response.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_error`  out  1  sticky protocol-error flag; cleared only by `rst`.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if `pmem_read` or `pmem_write` is high, latch the index, the operation and `pmem_wdata`, load the counter with LATENCY-1, and go to BUSY.
  - If LATENCY=1, go directly to RESP.
  - If both read and write are high: treat as a write, set `pmem_error`.
- BUSY: decrement the counter each cycle; at 0, go to RESP.
  - If the latched request line (`pmem_read` for a read, `pmem_write` for a write) drops, abort to IDLE. No response is given and no array update occurs.
  - Changes to `pmem_address` or `pmem_wdata` during BUSY are ignored; the latched values are used.
- RESP: assert `pmem_resp` for exactly one cycle, then return to IDLE.
  - Write: commit the latched line to `array[idx]` and set `valid[idx]`.
  - Read: drive `pmem_rdata` from `array[idx]` if `valid[idx]` is set, otherwise 128'h0.
- A request still high in the IDLE cycle after RESP is a new request. Back-to-back transactions therefore cost LATENCY+1 cycles each.
- Reset values: state IDLE, `pmem_resp`=0, `pmem_rdata`=0, `pmem_error`=0, counter 0, all valid bits 0. Array data is not reset.
- `rst` during BUSY or RESP: the transaction is dropped, with no commit and no `pmem_resp` that cycle.

## Timing
- Request first seen high in IDLE at cycle 0 → `pmem_resp` high in cycle LATENCY, and low in cycle LATENCY+1.
- `pmem_resp` and `pmem_rdata` are registered outputs; there is no combinational path from inputs to outputs.
- A write is visible to a read accepted in the IDLE cycle immediately after its RESP.
- The counter width is 8 bits.

## Structure
- `lc3b_types` supplies `lc3b_word` and `lc3b_data`.
- Add `lc3b_pmem_state` (IDLE/BUSY/RESP enum) to `lc3b_types` so the bench can probe the state.
- Sub-module `pmem_line_array`: 2^IDX_BITS × 128-bit storage plus resettable valid bits. It has one synchronous write port (`we`, `idx`, `wdata`) and one combinational read port (`idx` → `rdata`, `valid`).
- The top level holds the FSM, counter, latches and output registers.

## Test plan
- Reset, then read 16'h0040 with LATENCY=10 → `pmem_resp` exactly at cycle 10, `pmem_rdata`=128'h0, `pmem_error`=0.
- Write 16'h0040 with data 128'hDEADBEEF_..._0123, then read 16'h004F → resp at cycle 10 of each; the read returns the written line (offset bits ignored).
- With IDX_BITS=8, write 16'h0010 then read 16'h1010 → same line returned (aliasing).
- Drop `pmem_read` at cycle 5 of a read → no `pmem_resp`, FSM in IDLE; the next read completes after a full LATENCY.
- Raise `pmem_read` and `pmem_write` together on 16'h0020 → handled as a write, `pmem_error`=1 and it stays 1 until `rst`.
- Assert `rst` at cycle 9 of a write to 16'h0030, then read 16'h0030 → returns 0 (write not committed). With LATENCY=1, resp arrives at cycle 1.
